// File: rtl/avalon_wait_gen.sv
// Avalon wait-state generator: LFSR-driven stalls on each transaction plus an optional
// request-stability monitor, compiled in when AVALON_WAIT_MONITOR_EN is defined.
module avalon_wait_gen #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned MAX_WAIT  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitreq,
  output logic [3:0]  err_flags,
  output logic [31:0] txn_count,
  output logic [31:0] stall_count
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] SEED  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [3:0]  MAX_W = 4'(MAX_WAIT);

  typedef enum logic {IDLE, STALL} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] lfsr;
  logic        req;
  logic [3:0]  draw;
  logic        stall_raw;
  logic        accept;
  logic        start_stall;
  logic [15:0] lfsr_next;

  assign req         = read | write;
  assign draw        = (lfsr[3:0] > MAX_W) ? MAX_W : lfsr[3:0];
  assign stall_raw   = (state == IDLE) ? (req && (draw != 4'd0)) : (cnt != 4'd0);
  assign accept      = (state == IDLE) ? (req && (draw == 4'd0)) : (cnt == 4'd0);
  assign start_stall = (state == IDLE) && req && (draw != 4'd0);
  assign lfsr_next   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Gated by reset so the stall drops the instant reset is asserted.
  assign waitreq = reset & stall_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      lfsr        <= SEED;
      txn_count   <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (waitreq && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
      if (accept) begin
        lfsr <= lfsr_next;
        if (txn_count != 32'hFFFF_FFFF)
          txn_count <= txn_count + 32'd1;
      end
      case (state)
        IDLE: begin
          if (start_stall) begin
            cnt   <= draw - 4'd1;
            state <= STALL;
          end
        end
        STALL: begin
          if (cnt != 4'd0)
            cnt <= cnt - 4'd1;
          else
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AVALON_WAIT_MONITOR_EN
  logic        cap_read;
  logic        cap_write;
  logic [31:0] cap_address;
  logic [3:0]  cap_byteenable;
  logic [31:0] cap_writedata;
  logic [3:0]  err_q;
  logic [3:0]  err_now;

  // Both-high is illegal everywhere; the other checks only apply while stalled.
  always_comb begin
    err_now    = 4'b0000;
    err_now[2] = read & write;
    if (state == STALL) begin
      err_now[0] = ~req;
      err_now[1] = (address != cap_address) || (byteenable != cap_byteenable) ||
                   (cap_write && (writedata != cap_writedata));
      err_now[3] = req && (read != cap_read);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_read       <= 1'b0;
      cap_write      <= 1'b0;
      cap_address    <= 32'd0;
      cap_byteenable <= 4'd0;
      cap_writedata  <= 32'd0;
      err_q          <= 4'b0000;
    end else begin
      if (start_stall) begin
        cap_read       <= read;
        cap_write      <= write;
        cap_address    <= address;
        cap_byteenable <= byteenable;
        cap_writedata  <= writedata;
      end
      err_q <= err_q | err_now;
    end
  end

  assign err_flags = err_q;
`else
  logic unused_monitor_inputs;
  assign unused_monitor_inputs = ^{address, byteenable, writedata};
  assign err_flags = 4'b0000;
`endif

endmodule

// File: tb/tb_avalon_wait_gen.sv
// Directed bench for avalon_wait_gen: three instances with different seed/MAX_WAIT
// share the master stimulus; each test watches the instance it targets.
module tb_avalon_wait_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;

  logic [2:0]  wq;
  logic [3:0]  ef_z, ef_a, ef_c;
  logic [31:0] tc_z, tc_a, tc_c;
  logic [31:0] sc_z, sc_a, sc_c;

  int checks   = 0;
  int failures = 0;

`ifdef AVALON_WAIT_MONITOR_EN
  localparam bit MON_EN = 1'b1;
`else
  localparam bit MON_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  // Never stalls.
  avalon_wait_gen #(.LFSR_SEED(16'h0001), .MAX_WAIT(0)) dut_z (
    .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
    .byteenable(byteenable), .writedata(writedata), .waitreq(wq[0]),
    .err_flags(ef_z), .txn_count(tc_z), .stall_count(sc_z));

  // Unclamped draws from seed 1.
  avalon_wait_gen #(.LFSR_SEED(16'h0001), .MAX_WAIT(15)) dut_a (
    .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
    .byteenable(byteenable), .writedata(writedata), .waitreq(wq[1]),
    .err_flags(ef_a), .txn_count(tc_a), .stall_count(sc_a));

  // Zero seed (promoted to 1) with draws clamped to 1.
  avalon_wait_gen #(.LFSR_SEED(16'h0000), .MAX_WAIT(1)) dut_c (
    .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
    .byteenable(byteenable), .writedata(writedata), .waitreq(wq[2]),
    .err_flags(ef_c), .txn_count(tc_c), .stall_count(sc_c));

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    address    = 32'd0;
    byteenable = 4'hF;
    writedata  = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  // Counts waitreq-high cycles of one instance, then steps past the acceptance edge.
  task automatic measure_stall(input int sel, output int len);
    len = 0;
    #1;
    while (wq[sel] === 1'b1 && len < 20) begin
      @(posedge clk);
      #1;
      len++;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    read  = 1'b1;
    write = 1'b0;
    address = 32'h0; byteenable = 4'hF; writedata = 32'h0;
    #1;
    checks++;
    if (wq !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_waitreq: got %b expected 000", wq);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (tc_a !== 32'd0 || sc_a !== 32'd0 || ef_a !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_state_a: got txn=%0d stall=%0d err=%b expected 0/0/0000", tc_a, sc_a, ef_a);
    end
    checks++;
    if (tc_z !== 32'd0 || sc_z !== 32'd0 || ef_z !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_state_z: got txn=%0d stall=%0d err=%b expected 0/0/0000", tc_z, sc_z, ef_z);
    end
  endtask

  task automatic test_no_stall();
    do_reset();
    read    = 1'b1;
    address = 32'h0000_0100;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (wq[0] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL nostall_waitreq[%0d]: got %b expected 0", i, wq[0]);
      end
      @(posedge clk);
      #1;
    end
    read = 1'b0;
    #1;
    checks++;
    if (tc_z !== 32'd5 || sc_z !== 32'd0) begin
      failures++;
      $display("[TB] FAIL nostall_counts: got txn=%0d stall=%0d expected 5/0", tc_z, sc_z);
    end
  endtask

  task automatic test_stall_sequence();
    int exp_len[5] = '{1, 2, 4, 8, 0};
    int len;
    do_reset();
    read    = 1'b1;
    address = 32'hBFC0_0000;
    for (int i = 0; i < 5; i++) begin
      measure_stall(1, len);
      checks++;
      if (len !== exp_len[i]) begin
        failures++;
        $display("[TB] FAIL stall_len_a[%0d]: got %0d expected %0d", i, len, exp_len[i]);
      end
      if (i == 1) begin
        checks++;
        if (tc_a !== 32'd2 || sc_a !== 32'd3) begin
          failures++;
          $display("[TB] FAIL counts_after_two: got txn=%0d stall=%0d expected 2/3", tc_a, sc_a);
        end
      end
    end
    read = 1'b0;
    #1;
    checks++;
    if (tc_a !== 32'd5 || sc_a !== 32'd15) begin
      failures++;
      $display("[TB] FAIL counts_after_five: got txn=%0d stall=%0d expected 5/15", tc_a, sc_a);
    end
  endtask

  task automatic test_clamp();
    int exp_len[5] = '{1, 1, 1, 1, 0};
    int len;
    do_reset();
    read    = 1'b1;
    address = 32'h0000_2000;
    for (int i = 0; i < 5; i++) begin
      measure_stall(2, len);
      checks++;
      if (len !== exp_len[i]) begin
        failures++;
        $display("[TB] FAIL clamp_len[%0d]: got %0d expected %0d", i, len, exp_len[i]);
      end
    end
    read = 1'b0;
    #1;
    checks++;
    if (tc_c !== 32'd5 || sc_c !== 32'd4) begin
      failures++;
      $display("[TB] FAIL clamp_counts: got txn=%0d stall=%0d expected 5/4", tc_c, sc_c);
    end
  endtask

  task automatic test_addr_change();
    logic [3:0] exp_flags;
    int len;
    exp_flags = MON_EN ? 4'b0010 : 4'b0000;
    do_reset();
    read    = 1'b1;
    address = 32'hBFC0_0000;
    measure_stall(1, len);
    #1;
    checks++;
    if (ef_a !== 4'b0000 || wq[1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL addr_pre: got err=%b waitreq=%b expected 0000/1", ef_a, wq[1]);
    end
    next_cycle();
    address = 32'hBFC0_0004;
    next_cycle();
    next_cycle();
    read = 1'b0;
    for (int i = 0; i < 10; i++) next_cycle();
    checks++;
    if (ef_a !== exp_flags || tc_a !== 32'd2) begin
      failures++;
      $display("[TB] FAIL addr_change: got err=%b txn=%0d expected %b/2", ef_a, tc_a, exp_flags);
    end
  endtask

  task automatic test_drop_and_both();
    logic [3:0] exp_drop;
    logic [3:0] exp_both;
    exp_drop = MON_EN ? 4'b0001 : 4'b0000;
    exp_both = MON_EN ? 4'b0101 : 4'b0000;
    do_reset();
    write     = 1'b1;
    address   = 32'h0000_1000;
    writedata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (wq[1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL write_stall: got %b expected 1", wq[1]);
    end
    next_cycle();
    write = 1'b0;
    next_cycle();
    #1;
    checks++;
    if (ef_a !== exp_drop || tc_a !== 32'd1) begin
      failures++;
      $display("[TB] FAIL drop_flag: got err=%b txn=%0d expected %b/1", ef_a, tc_a, exp_drop);
    end
    read  = 1'b1;
    write = 1'b1;
    next_cycle();
    #1;
    checks++;
    if (ef_a !== exp_both) begin
      failures++;
      $display("[TB] FAIL both_flag: got err=%b expected %b", ef_a, exp_both);
    end
    read  = 1'b0;
    write = 1'b0;
    for (int i = 0; i < 4; i++) next_cycle();
    checks++;
    if (ef_a !== exp_both || tc_a !== 32'd2) begin
      failures++;
      $display("[TB] FAIL drop_both_final: got err=%b txn=%0d expected %b/2", ef_a, tc_a, exp_both);
    end
  endtask

  task automatic test_reset_mid_stall();
    int len;
    do_reset();
    read    = 1'b1;
    address = 32'h0000_3000;
    measure_stall(1, len);
    next_cycle();
    #1;
    checks++;
    if (wq[1] !== 1'b1 || tc_a !== 32'd1 || sc_a !== 32'd2) begin
      failures++;
      $display("[TB] FAIL pre_reset: got waitreq=%b txn=%0d stall=%0d expected 1/1/2", wq[1], tc_a, sc_a);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (wq[1] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_drop: got %b expected 0", wq[1]);
    end
    checks++;
    if (tc_a !== 32'd0 || sc_a !== 32'd0 || ef_a !== 4'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset_state: got txn=%0d stall=%0d err=%b expected 0/0/0000", tc_a, sc_a, ef_a);
    end
    next_cycle();
    reset = 1'b1;
    measure_stall(1, len);
    checks++;
    if (len !== 1) begin
      failures++;
      $display("[TB] FAIL repeat_draw: got %0d expected 1", len);
    end
    read = 1'b0;
    #1;
    checks++;
    if (tc_a !== 32'd1 || sc_a !== 32'd1) begin
      failures++;
      $display("[TB] FAIL post_reset_counts: got txn=%0d stall=%0d expected 1/1", tc_a, sc_a);
    end
  endtask

  initial begin
    test_reset();
    test_no_stall();
    test_stall_sequence();
    test_clamp();
    test_addr_change();
    test_drop_and_both();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
